sy_ppl_instr_queue: RTL

// - Fetch-side instruction queue directly downstream of the instruction realigner.
// - Accepts up to INSTR_PER_FETCH realigned instructions per cycle (addr + 32b word) and stores them in order.
// - Presents one instruction per cycle to decode through a valid/ready handshake.
// - Decouples fetch from decode stalls and drops all contents on a pipeline flush.

---
 rtl/sy_ppl_instr_queue.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/sy_ppl_instr_queue.sv
// Fetch-side instruction queue behind the realigner: in-order multi-slot push, single-entry pop.
// Optional empty-queue bypass when SY_INSTR_QUEUE_BYPASS_EN is defined.
module sy_ppl_instr_queue #(
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter int unsigned DEPTH           = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_i,
  input  logic [INSTR_PER_FETCH-1:0]         valid_i,
  input  logic [INSTR_PER_FETCH*64-1:0]      addr_i,
  input  logic [INSTR_PER_FETCH*32-1:0]      instr_i,
  output logic                               ready_o,
  output logic                               valid_o,
  output logic [63:0]                        addr_o,
  output logic [31:0]                        instr_o,
  output logic                               is_compressed_o,
  input  logic                               ready_i,
  output logic [$clog2(DEPTH+1)-1:0]         count_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned IDX_W = (INSTR_PER_FETCH > 1) ? $clog2(INSTR_PER_FETCH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] IPF_C   = CNT_W'(INSTR_PER_FETCH);

  function automatic logic [CNT_W-1:0] popcount(input logic [INSTR_PER_FETCH-1:0] v);
    logic [CNT_W-1:0] n;
    n = {CNT_W{1'b0}};
    for (int i = 0; i < INSTR_PER_FETCH; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  logic [63:0]          addr_mem_r  [DEPTH];
  logic [31:0]          instr_mem_r [DEPTH];
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [CNT_W-1:0]     count_r;

  logic                 push_en_s;
  logic                 pop_s;
  logic                 bypass_s;
  logic                 byp_pop_s;
  logic                 head_adv_s;
  logic [IDX_W-1:0]     first_s;
  logic [CNT_W-1:0]     push_cnt_s;
  logic [CNT_W-1:0]     wr_cnt_s;
  logic [INSTR_PER_FETCH-1:0] wr_en_s;
  logic [PTR_W-1:0]     wr_idx_s [INSTR_PER_FETCH];
  logic [63:0]          head_addr_s;
  logic [31:0]          head_instr_s;

  // Admission uses pre-pop occupancy so a full group always fits
  assign ready_o    = (DEPTH_C - count_r) >= IPF_C;
  assign push_en_s  = ready_o & ~flush_i;
  assign push_cnt_s = push_en_s ? popcount(valid_i) : {CNT_W{1'b0}};

`ifdef SY_INSTR_QUEUE_BYPASS_EN
  // Head selection: oldest valid input slot when the queue is empty, else storage
  always_comb begin
    bypass_s = (count_r == {CNT_W{1'b0}}) & push_en_s & (|valid_i);
    first_s  = {IDX_W{1'b0}};
    for (int i = INSTR_PER_FETCH - 1; i >= 0; i--) begin
      first_s = valid_i[i] ? IDX_W'(i) : first_s;
    end
    if (bypass_s) begin
      head_addr_s  = addr_i[int'(first_s)*64 +: 64];
      head_instr_s = instr_i[int'(first_s)*32 +: 32];
    end else begin
      head_addr_s  = addr_mem_r[rd_ptr_r];
      head_instr_s = instr_mem_r[rd_ptr_r];
    end
  end
`else
  // Head always comes from storage; no input-to-output path
  always_comb begin
    bypass_s     = 1'b0;
    first_s      = {IDX_W{1'b0}};
    head_addr_s  = addr_mem_r[rd_ptr_r];
    head_instr_s = instr_mem_r[rd_ptr_r];
  end
`endif

  assign valid_o         = ((count_r != {CNT_W{1'b0}}) | bypass_s) & ~flush_i;
  assign pop_s           = valid_o & ready_i;
  assign byp_pop_s       = bypass_s & ready_i;
  assign head_adv_s      = pop_s & ~byp_pop_s;
  assign addr_o          = head_addr_s;
  assign instr_o         = head_instr_s;
  assign is_compressed_o = valid_o & ~(&head_instr_s[1:0]);
  assign count_o         = count_r;

  // Compact valid slots in order; a bypassed-and-consumed slot is not stored
  always_comb begin
    logic [CNT_W-1:0] seen;
    seen = {CNT_W{1'b0}};
    for (int i = 0; i < INSTR_PER_FETCH; i++) begin
      wr_en_s[i]  = push_en_s & valid_i[i] & ~(byp_pop_s & (first_s == IDX_W'(i)));
      wr_idx_s[i] = wr_ptr_r + PTR_W'(seen);
      seen        = seen + CNT_W'(wr_en_s[i]);
    end
    wr_cnt_s = seen;
  end

  // Pointer and occupancy update; flush wins over push and pop
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_r  <= {CNT_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
    end else if (flush_i) begin
      count_r  <= {CNT_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
    end else begin
      count_r  <= count_r + wr_cnt_s - CNT_W'(head_adv_s);
      rd_ptr_r <= rd_ptr_r + PTR_W'(head_adv_s);
      wr_ptr_r <= wr_ptr_r + PTR_W'(wr_cnt_s);
    end
  end

  // Entry storage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int d = 0; d < DEPTH; d++) begin
        addr_mem_r[d]  <= 64'h0;
        instr_mem_r[d] <= 32'h0;
      end
    end else begin
      for (int i = 0; i < INSTR_PER_FETCH; i++) begin
        if (wr_en_s[i]) begin
          addr_mem_r[wr_idx_s[i]]  <= addr_i[i*64 +: 64];
          instr_mem_r[wr_idx_s[i]] <= instr_i[i*32 +: 32];
        end
      end
    end
  end

  sy_ppl_instr_queue_chk #(
    .DEPTH (DEPTH)
  ) u_chk (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_en_i  (push_en_s),
    .push_cnt_i (push_cnt_s),
    .count_i    (count_r)
  );

endmodule

// Simulation checks on occupancy bounds of the instruction queue.
module sy_ppl_instr_queue_chk #(
  parameter int unsigned DEPTH = 8
) (
  input logic                       clk_i,
  input logic                       rst_ni,
  input logic                       push_en_i,
  input logic [$clog2(DEPTH+1)-1:0] push_cnt_i,
  input logic [$clog2(DEPTH+1)-1:0] count_i
);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  a_no_overflow_push: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_en_i && (count_i > (DEPTH_C - push_cnt_i))));

  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_i <= DEPTH_C);
endmodule
